// File: rtl/multicycle_main_controller.sv
// Multicycle RV32I main control FSM with cache ready handshake,
// optional jalr/lui support and an optional memory-wait watchdog.
module multicycle_main_controller #(
  parameter  int EXT_ISA    = 0,
  parameter  int WAIT_LIMIT = 0,
  parameter  int CNT_W      = 8,
  localparam int IMM_W      = 2 + EXT_ISA
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [6:0]       OP6_0,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             MemReq,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc1_0,
  output logic [1:0]       ALUSrcA1_0,
  output logic [1:0]       ALUSrcB1_0,
  output logic [1:0]       ALUOP1_0,
  output logic [IMM_W-1:0] ImmSrc,
  output logic             IllegalOp,
  output logic             MemTimeout,
  output logic [3:0]       State
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam bit         EXT     = (EXT_ISA != 0);
  localparam bit         WD_EN   = (WAIT_LIMIT > 0);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,  S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,  S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,  S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,  S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,  S_BEQ      = 4'd9,
    S_JAL      = 4'd10, S_JALR     = 4'd11,
    S_JALRWB   = 4'd12, S_LUI      = 4'd13,
    S_HALT     = 4'd14
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             to_q;
  logic             mreq, mw, irw, pcupd, branch, rw, adr;
  logic             illegal, waiting, wd_expire;
  logic [1:0]       res, srca, srcb, aluop;
  logic [2:0]       imm;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_q | wd_expire;
    end
  end

  // Watchdog counts only stalled request cycles; MemReady on the limit cycle wins.
  assign waiting   = mreq & ~MemReady;
  assign cnt_inc   = cnt_q + 1'b1;
  assign wd_expire = WD_EN && waiting
                     && (cnt_inc == CNT_W'(WAIT_LIMIT));

  always_comb begin
    cnt_d = '0;
    if (WD_EN && state_d == state_q)
      cnt_d = waiting ? cnt_inc : cnt_q;
  end

  always_comb begin
    state_d = state_q;
    illegal = 1'b0;
    unique case (state_q)
      S_FETCH:    if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (OP6_0)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_JALR: begin
            state_d = EXT ? S_JALR : S_FETCH;
            illegal = !EXT;
          end
          OP_LUI: begin
            state_d = EXT ? S_LUI : S_FETCH;
            illegal = !EXT;
          end
          default: begin
            state_d = S_FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR:   state_d = (OP6_0 == OP_SW) ? S_MEMWRITE
                                             : S_MEMREAD;
      S_MEMREAD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWRITE: if (MemReady) state_d = S_FETCH;
      S_EXECUTER, S_EXECUTEI,
      S_JAL, S_LUI: state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
    if (wd_expire) state_d = S_HALT;
  end

  always_comb begin
    mreq = 1'b0; mw = 1'b0; irw = 1'b0; pcupd = 1'b0;
    branch = 1'b0; rw = 1'b0; adr = 1'b0;
    res = 2'b00; srca = 2'b00; srcb = 2'b00; aluop = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mreq = 1'b1; srcb = 2'b10; res = 2'b10;
        irw = MemReady; pcupd = MemReady;
      end
      S_DECODE:   begin srca = 2'b01; srcb = 2'b01; end
      S_MEMADR:   begin srca = 2'b10; srcb = 2'b01; end
      S_MEMREAD:  begin mreq = 1'b1; adr = 1'b1; end
      S_MEMWB:    begin res = 2'b01; rw = 1'b1; end
      S_MEMWRITE: begin mreq = 1'b1; adr = 1'b1; mw = 1'b1; end
      S_EXECUTER: begin srca = 2'b10; aluop = 2'b10; end
      S_EXECUTEI: begin
        srca = 2'b10; srcb = 2'b01; aluop = 2'b10;
      end
      S_ALUWB:    rw = 1'b1;
      S_BEQ: begin
        srca = 2'b10; aluop = 2'b01; branch = 1'b1;
      end
      S_JAL: begin
        srca = 2'b01; srcb = 2'b10; pcupd = 1'b1;
      end
      S_JALR: begin
        srca = 2'b10; srcb = 2'b01; res = 2'b10; pcupd = 1'b1;
      end
      S_JALRWB: begin
        srca = 2'b01; srcb = 2'b10; res = 2'b10; rw = 1'b1;
      end
      S_LUI:      begin srca = 2'b11; srcb = 2'b01; end
      default: ;
    endcase
  end

  always_comb begin
    imm = 3'b000;
    case (OP6_0)
      OP_SW:   imm = 3'b001;
      OP_BEQ:  imm = 3'b010;
      OP_JAL:  imm = 3'b011;
      OP_LUI:  imm = EXT ? 3'b100 : 3'b000;
      default: imm = 3'b000;
    endcase
  end

  // Strobes are held low for as long as reset is asserted.
  assign MemReq       = RST & mreq;
  assign MemWrite     = RST & mw;
  assign IRWrite      = RST & irw;
  assign PCWrite      = RST & (pcupd | (branch & Zero));
  assign RegWrite     = RST & rw;
  assign IllegalOp    = RST & illegal;
  assign AdrSrc       = adr;
  assign ResultSrc1_0 = res;
  assign ALUSrcA1_0   = srca;
  assign ALUSrcB1_0   = srcb;
  assign ALUOP1_0     = aluop;
  assign ImmSrc       = IMM_W'(imm);
  assign MemTimeout   = to_q;
  assign State        = state_q;

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Directed bench: base controller (a) beside an EXT_ISA=1,
// WAIT_LIMIT=4 controller (b) on shared stimulus.
module tb_multicycle_main_controller;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] LUI  = 7'b0110111;

  logic       clk = 1'b0;
  logic       rst, zero, rdy;
  logic [6:0] op;
  int         checks = 0;
  int         errors = 0;

  logic       a_req, a_adr, a_mw, a_irw, a_pcw, a_rw, a_ill, a_to;
  logic [1:0] a_res, a_sa, a_sb, a_aop, a_imm;
  logic [3:0] a_st;
  logic       b_req, b_adr, b_mw, b_irw, b_pcw, b_rw, b_ill, b_to;
  logic [1:0] b_res, b_sa, b_sb, b_aop;
  logic [2:0] b_imm;
  logic [3:0] b_st;

  always #5 clk = ~clk;

  multicycle_main_controller #(.EXT_ISA(0), .WAIT_LIMIT(0)) dut_a (
    .CLK(clk), .RST(rst), .OP6_0(op), .Zero(zero),
    .MemReady(rdy), .MemReq(a_req), .AdrSrc(a_adr),
    .MemWrite(a_mw), .IRWrite(a_irw), .PCWrite(a_pcw),
    .RegWrite(a_rw), .ResultSrc1_0(a_res), .ALUSrcA1_0(a_sa),
    .ALUSrcB1_0(a_sb), .ALUOP1_0(a_aop), .ImmSrc(a_imm),
    .IllegalOp(a_ill), .MemTimeout(a_to), .State(a_st)
  );

  multicycle_main_controller #(.EXT_ISA(1), .WAIT_LIMIT(4)) dut_b (
    .CLK(clk), .RST(rst), .OP6_0(op), .Zero(zero),
    .MemReady(rdy), .MemReq(b_req), .AdrSrc(b_adr),
    .MemWrite(b_mw), .IRWrite(b_irw), .PCWrite(b_pcw),
    .RegWrite(b_rw), .ResultSrc1_0(b_res), .ALUSrcA1_0(b_sa),
    .ALUSrcB1_0(b_sb), .ALUOP1_0(b_aop), .ImmSrc(b_imm),
    .IllegalOp(b_ill), .MemTimeout(b_to), .State(b_st)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [6:0] o, input logic r,
                     input logic z);
    @(negedge clk);
    op = o; rdy = r; zero = z;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

  initial begin
    logic [6:0] ill [3];
    ill[0] = 7'b0101010; ill[1] = 7'b0000000; ill[2] = 7'b1111111;
    rst = 1'b0; op = LW; rdy = 1'b1; zero = 1'b0;
    #1;
    chk("rst_state", a_st, 0);
    chk("rst_memreq", a_req, 0);
    chk("rst_irwrite", a_irw, 0);
    chk("rst_pcwrite", a_pcw, 0);
    chk("rst_b_memreq", b_req, 0);
    chk("rst_b_timeout", b_to, 0);

    // lw with zero-wait memory
    cyc(LW, 1, 0); rst = 1'b1; #1;
    chk("lw1_state", a_st, 0);
    chk("lw1_irwrite", a_irw, 1);
    chk("lw1_pcwrite", a_pcw, 1);
    chk("lw1_memreq", a_req, 1);
    chk("lw1_regwrite", a_rw, 0);
    cyc(LW, 1, 0);
    chk("lw2_state", a_st, 1);
    chk("lw2_srca", a_sa, 1);
    chk("lw2_regwrite", a_rw, 0);
    cyc(LW, 1, 0);
    chk("lw3_state", a_st, 2);
    chk("lw3_srca", a_sa, 2);
    cyc(LW, 1, 0);
    chk("lw4_state", a_st, 3);
    chk("lw4_adrsrc", a_adr, 1);
    chk("lw4_regwrite", a_rw, 0);
    cyc(LW, 1, 0);
    chk("lw5_state", a_st, 4);
    chk("lw5_regwrite", a_rw, 1);
    chk("lw5_ressrc", a_res, 1);

    // sw with three wait cycles in MEMWRITE
    cyc(SW, 1, 0);
    chk("sw1_state", a_st, 0);
    cyc(SW, 1, 0);
    chk("sw2_imm", a_imm, 1);
    cyc(SW, 1, 0);
    chk("sw3_state", a_st, 2);
    for (int i = 0; i < 4; i++) begin
      cyc(SW, (i == 3), 0);
      chk("sw_wr_state", a_st, 5);
      chk("sw_wr_memwrite", a_mw, 1);
      chk("sw_wr_memreq", a_req, 1);
      chk("sw_wr_regwrite", a_rw, 0);
      chk("sw_wr_b_memwrite", b_mw, 1);
    end

    // beq taken then not taken
    cyc(BEQ, 1, 0);
    chk("sw_done_state", a_st, 0);
    cyc(BEQ, 1, 1);
    chk("beq_imm", a_imm, 2);
    chk("beq_dec_pcwrite", a_pcw, 0);
    cyc(BEQ, 1, 1);
    chk("beq_t_state", a_st, 9);
    chk("beq_t_pcwrite", a_pcw, 1);
    chk("beq_t_aluop", a_aop, 1);
    cyc(BEQ, 1, 0);
    chk("beq_t_next", a_st, 0);
    cyc(BEQ, 1, 0);
    cyc(BEQ, 1, 0);
    chk("beq_n_state", a_st, 9);
    chk("beq_n_pcwrite", a_pcw, 0);
    chk("beq_n_aluop", a_aop, 1);

    // undefined opcodes
    for (int i = 0; i < 3; i++) begin
      cyc(ill[i], 1, 0);
      chk("ill_fetch_state", a_st, 0);
      chk("ill_fetch_pulse", a_ill, 0);
      cyc(ill[i], 1, 0);
      chk("ill_dec_a", a_ill, 1);
      chk("ill_dec_b", b_ill, 1);
      chk("ill_dec_state", a_st, 1);
      chk("ill_dec_rw", a_rw, 0);
      chk("ill_dec_mw", a_mw, 0);
      chk("ill_dec_imm", a_imm, 0);
    end

    // jalr: illegal on a, two-step on b
    cyc(JALR, 1, 0);
    chk("jalr_fetch_a", a_st, 0);
    chk("jalr_fetch_b", b_st, 0);
    cyc(JALR, 1, 0);
    chk("jalr_dec_ill_a", a_ill, 1);
    chk("jalr_dec_ill_b", b_ill, 0);
    chk("jalr_dec_imm_b", b_imm, 0);
    cyc(LUI, 1, 0);
    chk("jalr_a_back", a_st, 0);
    chk("jalr_b_state", b_st, 11);
    chk("jalr_b_pcwrite", b_pcw, 1);
    chk("jalr_b_ressrc", b_res, 2);
    chk("jalr_b_srca", b_sa, 2);
    cyc(LUI, 1, 0);
    chk("jalrwb_b_state", b_st, 12);
    chk("jalrwb_b_rw", b_rw, 1);
    chk("jalrwb_b_srca", b_sa, 1);
    chk("lui_a_ill", a_ill, 1);
    chk("lui_a_imm", a_imm, 0);
    chk("lui_a_rw", a_rw, 0);

    // lui on b
    cyc(LUI, 1, 0);
    chk("lui_fetch_b", b_st, 0);
    chk("lui_fetch_a", a_st, 0);
    cyc(LUI, 1, 0);
    chk("lui_dec_imm_b", b_imm, 4);
    chk("lui_dec_ill_b", b_ill, 0);
    cyc(LUI, 1, 0);
    chk("lui_b_state", b_st, 13);
    chk("lui_b_srca", b_sa, 3);
    chk("lui_b_srcb", b_sb, 1);
    cyc(LUI, 1, 0);
    chk("lui_wb_state", b_st, 8);
    chk("lui_wb_rw", b_rw, 1);

    // resynchronise, then abort a store with reset
    cyc(SW, 1, 0); rst = 1'b0; #1;
    chk("rst2_state_a", a_st, 0);
    chk("rst2_state_b", b_st, 0);
    chk("rst2_memreq", b_req, 0);
    cyc(SW, 1, 0); rst = 1'b1; #1;
    chk("rel2_state", b_st, 0);
    chk("rel2_memreq", b_req, 1);
    cyc(SW, 1, 0);
    cyc(SW, 1, 0);
    cyc(SW, 0, 0);
    chk("abort_pre_state", b_st, 5);
    chk("abort_pre_mw", b_mw, 1);
    #2 rst = 1'b0;
    #1;
    chk("abort_mw_b", b_mw, 0);
    chk("abort_mw_a", a_mw, 0);
    chk("abort_state", b_st, 0);
    chk("abort_timeout", b_to, 0);

    // watchdog: four stalled fetch cycles then HALT on b
    cyc(SW, 0, 0); rst = 1'b1; #1;
    chk("wd1_state", b_st, 0);
    chk("wd1_memreq", b_req, 1);
    chk("wd1_irwrite", a_irw, 0);
    chk("wd1_pcwrite", a_pcw, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(SW, 0, 0);
      chk("wd_wait_state", b_st, 0);
      chk("wd_wait_to", b_to, 0);
    end
    cyc(SW, 0, 0);
    chk("wd_halt_state", b_st, 14);
    chk("wd_halt_to", b_to, 1);
    chk("wd_halt_memreq", b_req, 0);
    chk("wd_a_state", a_st, 0);
    chk("wd_a_to", a_to, 0);
    cyc(SW, 1, 0);
    chk("wd_hold_state", b_st, 14);
    chk("wd_hold_memreq", b_req, 0);
    chk("wd_hold_irw", b_irw, 0);
    chk("wd_hold_to", b_to, 1);
    rst = 1'b0; #1;
    chk("wd_rst_state", b_st, 0);
    chk("wd_rst_to", b_to, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
